fir_lane_serializer: RTL and testbench

// - Output-side companion of the 3-parallel FIR (unfolding factor 3).
// - Accepts one 3-lane output triple (DIN_0..DIN_2) per VIN strobe and buffers it in a small FIFO.
// - Replays the samples as a 1-sample/cycle stream under a valid/ready handshake, in time order: lane 0, then 1, then 2.
// - Sits between the filter's DOUT_0..2/VOUT and a serial data sink or file writer.

---
 rtl/fir_lane_serializer.sv | 96 +++++++++
 tb/tb_fir_lane_serializer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fir_lane_serializer.sv
// fir_lane_serializer: buffers 3-lane FIR output triples in a small FIFO and
// replays them as a one-sample-per-cycle valid/ready stream (lane 0, 1, 2).
module fir_lane_serializer #(
  parameter int NB    = 8,
  parameter int DEPTH = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [NB-1:0] DIN_0,
  input  logic [NB-1:0] DIN_1,
  input  logic [NB-1:0] DIN_2,
  output logic          RDY_OUT,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  input  logic          RDY,
  output logic          OVF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Entry layout is {lane2, lane1, lane0}; storage is data only, never reset.
  logic [3*NB-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [1:0]      lane_cnt;
  logic            ovf;

  logic            full;
  logic            wr_en;
  logic            xfer;
  logic            pop;
  logic [3*NB-1:0] head;

  // Handshake decisions; full comes only from the registered count so a
  // same-cycle pop never opens room for a write.
  always_comb begin
    full  = (count == CW'(DEPTH));
    wr_en = VIN && !full;
    xfer  = (count != '0) && RDY;
    pop   = xfer && (lane_cnt == 2'd2);
  end

  // Storage write port.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= {DIN_2, DIN_1, DIN_0};
    end
  end

  // Control state: pointers, fill count, lane counter and sticky overflow.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      lane_cnt <= 2'd0;
      ovf      <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (VIN && full) begin
        ovf <= 1'b1;
      end
      if (xfer) begin
        lane_cnt <= (lane_cnt == 2'd2) ? 2'd0 : lane_cnt + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_en && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !wr_en) begin
        count <= count - CW'(1);
      end
    end
  end

  // First-word-fall-through read side: pick the current lane of the head entry.
  always_comb begin
    head = mem[rd_ptr];
    DOUT = head[NB-1:0];
    case (lane_cnt)
      2'd1:    DOUT = head[2*NB-1:NB];
      2'd2:    DOUT = head[3*NB-1:2*NB];
      default: DOUT = head[NB-1:0];
    endcase
    VOUT    = (count != '0);
    RDY_OUT = !full;
    OVF     = ovf;
  end

endmodule

// File: tb/tb_fir_lane_serializer.sv
// Testbench for fir_lane_serializer: directed scenarios followed by random
// traffic, all checked against a sample-queue reference model.
module tb_fir_lane_serializer;

  localparam int NB    = 8;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          VIN = 1'b0;
  logic [NB-1:0] DIN_0 = '0;
  logic [NB-1:0] DIN_1 = '0;
  logic [NB-1:0] DIN_2 = '0;
  logic          RDY_OUT;
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic          RDY = 1'b0;
  logic          OVF;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: the stream of samples still owed to the sink, plus OVF.
  logic [NB-1:0] q[$];
  logic          m_ovf = 1'b0;

  fir_lane_serializer #(.NB(NB), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .VIN(VIN),
    .DIN_0(DIN_0), .DIN_1(DIN_1), .DIN_2(DIN_2),
    .RDY_OUT(RDY_OUT), .DOUT(DOUT), .VOUT(VOUT), .RDY(RDY), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  function automatic bit m_full();
    // Triples still occupying storage = samples owed, rounded up to triples.
    return ((q.size() + 2) / 3) == DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".vout"}, 32'(VOUT), 32'(q.size() != 0));
    chk({tag, ".rdy_out"}, 32'(RDY_OUT), 32'(!m_full()));
    chk({tag, ".ovf"}, 32'(OVF), 32'(m_ovf));
    if (q.size() != 0) chk({tag, ".dout"}, 32'(DOUT), 32'(q[0]));
  endtask

  // Apply inputs for one cycle, advance the model, then cross the edge.
  task automatic drive(input logic rst, input logic vin, input logic [NB-1:0] d0,
                       input logic [NB-1:0] d1, input logic [NB-1:0] d2, input logic rdy);
    bit full_now;
    RST = rst; VIN = vin; DIN_0 = d0; DIN_1 = d1; DIN_2 = d2; RDY = rdy;
    full_now = m_full();
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (rdy && q.size() != 0) void'(q.pop_front());
      if (vin && !full_now) begin
        q.push_back(d0); q.push_back(d1); q.push_back(d2);
      end else if (vin) begin
        m_ovf = 1'b1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic cyc(input string tag, input logic rst, input logic vin, input logic [NB-1:0] d0,
                     input logic [NB-1:0] d1, input logic [NB-1:0] d2, input logic rdy);
    check_model(tag);
    drive(rst, vin, d0, d1, d2, rdy);
  endtask

  initial begin
    // T1 reset
    drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    cyc("t1", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t1.vout0", 32'(VOUT), 32'd0);
    chk("t1.rdyout1", 32'(RDY_OUT), 32'd1);
    chk("t1.ovf0", 32'(OVF), 32'd0);

    // T2 single triple
    cyc("t2w", 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b1);
    chk("t2.s0", 32'(DOUT), 32'h11);
    cyc("t2a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t2.s1", 32'(DOUT), 32'h22);
    cyc("t2b", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t2.s2", 32'(DOUT), 32'h33);
    cyc("t2c", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t2.empty", 32'(VOUT), 32'd0);

    // T3 fill and overflow with the sink stalled
    for (int i = 0; i < 5; i++) begin
      cyc("t3w", 1'b0, 1'b1, 8'(8'h40 + 3*i), 8'(8'h41 + 3*i), 8'(8'h42 + 3*i), 1'b0);
      if (i == 3) chk("t3.full", 32'(RDY_OUT), 32'd0);
    end
    chk("t3.ovf", 32'(OVF), 32'd1);
    for (int i = 0; i < 12; i++) begin
      chk("t3.seq", 32'(DOUT), 32'(8'h40 + i));
      cyc("t3r", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    end
    chk("t3.drained", 32'(VOUT), 32'd0);
    chk("t3.ovf_sticky", 32'(OVF), 32'd1);

    // T4 backpressure in the middle of a triple
    cyc("t4w", 1'b0, 1'b1, 8'hA0, 8'hA1, 8'hA2, 1'b1);
    cyc("t4a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t4.hold1", 32'(DOUT), 32'hA1);
    cyc("t4b", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4.hold2", 32'(DOUT), 32'hA1);
    cyc("t4c", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t4.hold3", 32'(DOUT), 32'hA1);
    cyc("t4d", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t4.last", 32'(DOUT), 32'hA2);
    cyc("t4e", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t4.done", 32'(VOUT), 32'd0);

    // T5 full with a lane-2 pop while a write is offered
    cyc("t5r", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("t5f", 1'b0, 1'b1, 8'(8'h60 + i), 8'(8'h70 + i), 8'(8'h80 + i), 1'b0);
    cyc("t5a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc("t5b", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t5.full", 32'(RDY_OUT), 32'd0);
    chk("t5.ovf0", 32'(OVF), 32'd0);
    cyc("t5p", 1'b0, 1'b1, 8'h55, 8'h55, 8'h55, 1'b1);
    chk("t5.rdyout", 32'(RDY_OUT), 32'd1);
    chk("t5.ovf1", 32'(OVF), 32'd1);
    chk("t5.next", 32'(DOUT), 32'h61);
    for (int i = 0; i < 9; i++) cyc("t5d", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    chk("t5.nodrop", 32'(VOUT), 32'd0);

    // T6 reset in the middle of a triple
    cyc("t6w", 1'b0, 1'b1, 8'h10, 8'h20, 8'h30, 1'b1);
    cyc("t6a", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    cyc("t6r", 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    chk("t6.vout0", 32'(VOUT), 32'd0);
    chk("t6.ovf0", 32'(OVF), 32'd0);
    cyc("t6n", 1'b0, 1'b1, 8'h01, 8'h02, 8'h03, 1'b1);
    chk("t6.first", 32'(DOUT), 32'h01);
    for (int i = 0; i < 3; i++) cyc("t6d", 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

    // Random traffic with occasional stalls, bursts and resets
    for (int i = 0; i < 600; i++) begin
      logic rst_r, vin_r, rdy_r;
      rst_r = ($urandom_range(0, 149) == 0);
      vin_r = ($urandom_range(0, 2) == 0) || (i % 100 > 80);
      rdy_r = ($urandom_range(0, 9) < 7) && !(i % 100 > 80);
      cyc("rnd", rst_r, vin_r, 8'($urandom), 8'($urandom), 8'($urandom), rdy_r);
    end
    check_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
